// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants for the SRAM-backed FIFO controller.
package sram_fifo_ctrl_pkg;

    // Output buffer holds up to two items, enough to cover the 1-cycle SRAM read.
    localparam int OB_ENTRIES = 2;
    // Width of the output buffer occupancy count (0..OB_ENTRIES).
    localparam int OB_CNT_W   = 2;

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Client handshake and SRAM port bundle for sram_fifo_ctrl.
// slave: the controller. master: the surrounding logic (clients + SRAM macro).
interface sram_fifo_ctrl_if #(
    parameter int WIDTH    = 8,
    parameter int LG_DEPTH = 6
) ();

    logic                  io_enq_valid;
    logic                  io_enq_ready;
    logic [WIDTH-1:0]      io_enq_bits;
    logic                  io_deq_valid;
    logic                  io_deq_ready;
    logic [WIDTH-1:0]      io_deq_bits;
    logic [LG_DEPTH+1:0]   io_count;
    logic [WIDTH-1:0]      io_sram_dinW;
    logic [LG_DEPTH-1:0]   io_sram_addrW;
    logic                  io_sram_weW;
    logic [LG_DEPTH-1:0]   io_sram_addrR;
    logic [WIDTH-1:0]      io_sram_doutR;

    modport slave (
        input  io_enq_valid, io_enq_bits, io_deq_ready, io_sram_doutR,
        output io_enq_ready, io_deq_valid, io_deq_bits, io_count,
               io_sram_dinW, io_sram_addrW, io_sram_weW, io_sram_addrR
    );

    modport master (
        output io_enq_valid, io_enq_bits, io_deq_ready, io_sram_doutR,
        input  io_enq_ready, io_deq_valid, io_deq_bits, io_count,
               io_sram_dinW, io_sram_addrW, io_sram_weW, io_sram_addrR
    );

endinterface

// File: rtl/sram_fifo_outbuf.sv
// Two-entry output buffer: absorbs SRAM read data and presents it as a
// valid/ready stream. Entry 0 is always the head; a pop shifts entry 1 down.
module sram_fifo_outbuf
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_valid,
    input  logic [WIDTH-1:0]    push_data,
    output logic                pop_valid,
    input  logic                pop_ready,
    output logic [WIDTH-1:0]    pop_data,
    output logic [OB_CNT_W-1:0] ocount
);

    logic [WIDTH-1:0]    data0_q, data0_d;
    logic [WIDTH-1:0]    data1_q, data1_d;
    logic [OB_CNT_W-1:0] ocount_q, ocount_d;
    logic [OB_CNT_W-1:0] base;
    logic                pop;

    assign pop       = pop_ready && (ocount_q != '0);
    assign pop_valid = (ocount_q != '0);
    assign pop_data  = data0_q;
    assign ocount    = ocount_q;

    // Pop first (shift down), then place a push into the first free slot.
    // Handles push+pop at occupancy 1 by writing the new item straight to the head.
    always_comb begin
        data0_d  = data0_q;
        data1_d  = data1_q;
        base     = ocount_q;
        if (pop) begin
            data0_d = data1_q;
            base    = ocount_q - 2'd1;
        end
        if (push_valid) begin
            if (base == '0) begin
                data0_d = push_data;
            end else begin
                data1_d = push_data;
            end
        end
        ocount_d = base + {1'b0, push_valid};
    end

    // Buffer storage and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data0_q  <= '0;
            data1_q  <= '0;
            ocount_q <= '0;
        end else begin
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            ocount_q <= ocount_d;
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around an external 1R1W SRAM with 1-cycle registered read.
// Writes go straight to the SRAM; reads are issued early enough that the
// output buffer never starves, giving 1 item/cycle on both sides.
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int LG_DEPTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    sram_fifo_ctrl_if.slave  bus
);

    localparam int                  CNT_W   = LG_DEPTH + 1;
    localparam logic [LG_DEPTH-1:0] PTR_ONE = {{(LG_DEPTH-1){1'b0}}, 1'b1};

    logic [LG_DEPTH-1:0] wptr_q, wptr_d;
    logic [LG_DEPTH-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]    scount_q, scount_d;
    logic                inflight_q, inflight_d;

    logic                enq_ready;
    logic                enq_fire;
    logic                deq_valid;
    logic                deq_fire;
    logic                rd;
    logic [OB_CNT_W-1:0] ocount;
    logic [OB_CNT_W-1:0] occ_after;

    // Full is judged from registered SRAM occupancy only; a same-cycle read
    // does not free space until the next cycle.
    assign enq_ready = (scount_q < CNT_W'(DEPTH));
    assign enq_fire  = bus.io_enq_valid && enq_ready;
    assign deq_fire  = deq_valid && bus.io_deq_ready;

    // Output buffer slots still claimed after this cycle's pop; an in-flight
    // read already owns one of them.
    assign occ_after = ocount + {1'b0, inflight_q} - {1'b0, deq_fire};
    assign rd        = (scount_q != '0) && (occ_after < OB_CNT_W'(OB_ENTRIES));

    assign bus.io_enq_ready  = enq_ready;
    assign bus.io_sram_weW   = enq_fire;
    assign bus.io_sram_addrW = wptr_q;
    assign bus.io_sram_dinW  = bus.io_enq_bits;
    assign bus.io_sram_addrR = rptr_q;
    assign bus.io_deq_valid  = deq_valid;
    assign bus.io_count      = {1'b0, scount_q}
                             + {{CNT_W{1'b0}}, inflight_q}
                             + {{LG_DEPTH{1'b0}}, ocount};

    // Pointer, SRAM occupancy and in-flight read bookkeeping.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        scount_d   = scount_q + {{LG_DEPTH{1'b0}}, enq_fire} - {{LG_DEPTH{1'b0}}, rd};
        inflight_d = rd;
        if (enq_fire) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            scount_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            scount_q   <= scount_d;
            inflight_q <= inflight_d;
        end
    end

    sram_fifo_outbuf #(
        .WIDTH (WIDTH)
    ) u_outbuf (
        .clk        (clk),
        .reset      (reset),
        .push_valid (inflight_q),
        .push_data  (bus.io_sram_doutR),
        .pop_valid  (deq_valid),
        .pop_ready  (bus.io_deq_ready),
        .pop_data   (bus.io_deq_bits),
        .ocount     (ocount)
    );

endmodule
